// File: rtl/stm32_bus_interface.sv
// stm32_bus_interface
//   Parallel-bus slave between the STM32 MCU and the DDC/DUC datapath.
//   Every clk_in cycle is one bus beat. A beat with DATA_SYNC high carries an
//   opcode and starts a new transaction, abandoning any transaction that was
//   still in progress without committing it.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no transaction; non-sync beats are ignored
//   PARAMS | flags beat, then frequency word MSB beat first; commit on last
//   STATUS | one beat returning {tx, rx_new, otr_sticky}
//   TX_IQ  | Q then I sample shifted in; TX_I/TX_Q update on last beat
//   RX_IQ  | RX snapshot shifted out, ch0 Q, ch0 I, ch1 Q, ... MSB first
//   TEST   | four beats of DATA_IN looped back to DATA_OUT
//
// Ports
//   clk_in, reset_n         clock, asynchronous active-low reset
//   DATA_IN, DATA_SYNC      MCU-to-FPGA beat and command marker
//   ADC_OTR                 ADC overrange, held in a sticky flag
//   rx_i, rx_q, rx_valid    RX samples per channel (ch0 in LSBs), new-set flag
//   DATA_OUT                registered FPGA-to-MCU beat
//   freq_out, preamp_enable, rx, tx   committed radio parameters
//   TX_I, TX_Q, tx_valid    TX sample pair and one-cycle update strobe
//   cmd_error               one-cycle strobe on an unknown opcode
//   stage_debug             current state encoding
module stm32_bus_interface #(
    parameter int BUS_WIDTH    = 4,
    parameter int SAMPLE_WIDTH = 16,
    parameter int FREQ_WIDTH   = 22,
    parameter int RX_CHANNELS  = 2,
    parameter logic [FREQ_WIDTH-1:0] FREQ_RESET = FREQ_WIDTH'(620407)
) (
    input  logic                                clk_in,
    input  logic                                reset_n,
    input  logic [BUS_WIDTH-1:0]                DATA_IN,
    input  logic                                DATA_SYNC,
    input  logic                                ADC_OTR,
    input  logic [RX_CHANNELS*SAMPLE_WIDTH-1:0] rx_i,
    input  logic [RX_CHANNELS*SAMPLE_WIDTH-1:0] rx_q,
    input  logic                                rx_valid,
    output logic [BUS_WIDTH-1:0]                DATA_OUT,
    output logic [FREQ_WIDTH-1:0]               freq_out,
    output logic                                preamp_enable,
    output logic                                rx,
    output logic                                tx,
    output logic [SAMPLE_WIDTH-1:0]             TX_I,
    output logic [SAMPLE_WIDTH-1:0]             TX_Q,
    output logic                                tx_valid,
    output logic                                cmd_error,
    output logic [7:0]                          stage_debug
);

    localparam int FB          = (FREQ_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int SB          = SAMPLE_WIDTH / BUS_WIDTH;
    localparam int IQ_W        = 2 * SAMPLE_WIDTH;
    localparam int SNAP_W      = 2 * RX_CHANNELS * SAMPLE_WIDTH;
    localparam int PARAM_BEATS = 1 + FB;
    localparam int TXIQ_BEATS  = 2 * SB;
    localparam int RXIQ_BEATS  = 2 * SB * RX_CHANNELS;
    localparam int TEST_BEATS  = 4;
    localparam int MAX_A       = (PARAM_BEATS > RXIQ_BEATS) ? PARAM_BEATS : RXIQ_BEATS;
    localparam int MAX_BEATS   = (MAX_A > TEST_BEATS) ? MAX_A : TEST_BEATS;
    localparam int CNT_W       = $clog2(MAX_BEATS + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PARAMS = 3'd1,
        STATUS = 3'd2,
        TX_IQ  = 3'd3,
        RX_IQ  = 3'd4,
        TEST   = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        beats_q, beats_d;
    logic [FREQ_WIDTH-1:0]   freq_sh_q, freq_sh_d;
    logic                    tx_sh_q, tx_sh_d;
    logic                    pre_sh_q, pre_sh_d;
    logic [IQ_W-1:0]         iq_sh_q, iq_sh_d;
    logic [SNAP_W-1:0]       snap_q, snap_d;
    logic [FREQ_WIDTH-1:0]   freq_q, freq_d;
    logic                    pre_q, pre_d;
    logic                    tx_q, tx_d;
    logic [SAMPLE_WIDTH-1:0] txi_q, txi_d;
    logic [SAMPLE_WIDTH-1:0] txq_q, txq_d;
    logic                    txv_q, txv_d;
    logic                    err_q, err_d;
    logic [BUS_WIDTH-1:0]    dout_q, dout_d;
    logic                    otr_q, otr_d;
    logic                    rx_new_q, rx_new_d;

    logic [SNAP_W-1:0]       snap_pack;
    logic [FREQ_WIDTH-1:0]   freq_shift;
    logic [IQ_W-1:0]         iq_shift;
    logic                    last_beat;

    // Bits of the oversized top frequency beat fall off the MSB end of the
    // shift, which leaves exactly the low remainder bits of that beat.
    assign freq_shift = (freq_sh_q << BUS_WIDTH) | FREQ_WIDTH'(DATA_IN);
    assign iq_shift   = (iq_sh_q << BUS_WIDTH) | IQ_W'(DATA_IN);
    assign last_beat  = (beats_q == CNT_W'(1));

    // Snapshot laid out in transmit order so the top beat is always next out.
    always_comb begin
        snap_pack = '0;
        for (int ch = 0; ch < RX_CHANNELS; ch++) begin
            snap_pack[SNAP_W-1-(2*ch)*SAMPLE_WIDTH -: SAMPLE_WIDTH]   = rx_q[ch*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            snap_pack[SNAP_W-1-(2*ch+1)*SAMPLE_WIDTH -: SAMPLE_WIDTH] = rx_i[ch*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
    end

    always_comb begin
        state_d   = state_q;
        beats_d   = beats_q;
        freq_sh_d = freq_sh_q;
        tx_sh_d   = tx_sh_q;
        pre_sh_d  = pre_sh_q;
        iq_sh_d   = iq_sh_q;
        snap_d    = snap_q;
        freq_d    = freq_q;
        pre_d     = pre_q;
        tx_d      = tx_q;
        txi_d     = txi_q;
        txq_d     = txq_q;
        dout_d    = dout_q;
        txv_d     = 1'b0;
        err_d     = 1'b0;
        otr_d     = otr_q | ADC_OTR;
        rx_new_d  = rx_new_q | rx_valid;

        if (DATA_SYNC) begin
            beats_d = '0;
            case (DATA_IN[3:0])
                4'h1: begin state_d = PARAMS; beats_d = CNT_W'(PARAM_BEATS); end
                4'h2: begin state_d = STATUS; beats_d = CNT_W'(1); end
                4'h3: begin state_d = TX_IQ;  beats_d = CNT_W'(TXIQ_BEATS); end
                4'h4: begin
                    state_d = RX_IQ;
                    beats_d = CNT_W'(RXIQ_BEATS);
                    snap_d  = snap_pack;
                end
                4'hA: begin state_d = TEST;   beats_d = CNT_W'(TEST_BEATS); end
                default: begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            endcase
        end else if (state_q != IDLE) begin
            beats_d = beats_q - CNT_W'(1);
            if (last_beat) begin
                state_d = IDLE;
            end
            case (state_q)
                PARAMS: begin
                    if (beats_q == CNT_W'(PARAM_BEATS)) begin
                        tx_sh_d  = DATA_IN[3];
                        pre_sh_d = DATA_IN[2];
                    end else begin
                        freq_sh_d = freq_shift;
                        if (last_beat) begin
                            freq_d = freq_shift;
                            pre_d  = pre_sh_q;
                            tx_d   = tx_sh_q;
                        end
                    end
                end
                STATUS: begin
                    dout_d = BUS_WIDTH'({tx_q, rx_new_q, otr_q});
                    otr_d  = ADC_OTR;
                end
                TX_IQ: begin
                    iq_sh_d = iq_shift;
                    if (last_beat) begin
                        txq_d = iq_shift[IQ_W-1 -: SAMPLE_WIDTH];
                        txi_d = iq_shift[SAMPLE_WIDTH-1:0];
                        txv_d = 1'b1;
                    end
                end
                RX_IQ: begin
                    dout_d = snap_q[SNAP_W-1 -: BUS_WIDTH];
                    snap_d = snap_q << BUS_WIDTH;
                    if (beats_q == CNT_W'(RXIQ_BEATS)) begin
                        rx_new_d = rx_valid;
                    end
                end
                TEST: begin
                    dout_d = DATA_IN;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            beats_q   <= '0;
            freq_sh_q <= '0;
            tx_sh_q   <= 1'b0;
            pre_sh_q  <= 1'b0;
            iq_sh_q   <= '0;
            snap_q    <= '0;
            freq_q    <= FREQ_RESET;
            pre_q     <= 1'b0;
            tx_q      <= 1'b0;
            txi_q     <= '0;
            txq_q     <= '0;
            txv_q     <= 1'b0;
            err_q     <= 1'b0;
            dout_q    <= '0;
            otr_q     <= 1'b0;
            rx_new_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            beats_q   <= beats_d;
            freq_sh_q <= freq_sh_d;
            tx_sh_q   <= tx_sh_d;
            pre_sh_q  <= pre_sh_d;
            iq_sh_q   <= iq_sh_d;
            snap_q    <= snap_d;
            freq_q    <= freq_d;
            pre_q     <= pre_d;
            tx_q      <= tx_d;
            txi_q     <= txi_d;
            txq_q     <= txq_d;
            txv_q     <= txv_d;
            err_q     <= err_d;
            dout_q    <= dout_d;
            otr_q     <= otr_d;
            rx_new_q  <= rx_new_d;
        end
    end

    assign DATA_OUT      = dout_q;
    assign freq_out      = freq_q;
    assign preamp_enable = pre_q;
    assign tx            = tx_q;
    assign rx            = ~tx_q;
    assign TX_I          = txi_q;
    assign TX_Q          = txq_q;
    assign tx_valid      = txv_q;
    assign cmd_error     = err_q;
    assign stage_debug   = {5'b0, state_q};

endmodule

// File: tb/tb_stm32_bus_interface.sv
module tb_stm32_bus_interface;

    localparam int BW = 4;
    localparam int SW = 16;
    localparam int FW = 22;
    localparam int RC = 2;

    localparam int S_FREQ  = 0;
    localparam int S_PRE   = 1;
    localparam int S_RX    = 2;
    localparam int S_TX    = 3;
    localparam int S_DOUT  = 4;
    localparam int S_TXI   = 5;
    localparam int S_TXQ   = 6;
    localparam int S_TXV   = 7;
    localparam int S_ERR   = 8;
    localparam int S_STAGE = 9;

    logic             clk_in = 1'b0;
    logic             reset_n = 1'b0;
    logic [BW-1:0]    DATA_IN = '0;
    logic             DATA_SYNC = 1'b0;
    logic             ADC_OTR = 1'b0;
    logic [RC*SW-1:0] rx_i = '0;
    logic [RC*SW-1:0] rx_q = '0;
    logic             rx_valid = 1'b0;
    logic [BW-1:0]    DATA_OUT;
    logic [FW-1:0]    freq_out;
    logic             preamp_enable, rx, tx, tx_valid, cmd_error;
    logic [SW-1:0]    TX_I, TX_Q;
    logic [7:0]       stage_debug;

    stm32_bus_interface #(
        .BUS_WIDTH(BW), .SAMPLE_WIDTH(SW), .FREQ_WIDTH(FW), .RX_CHANNELS(RC),
        .FREQ_RESET(22'd620407)
    ) dut (
        .clk_in(clk_in), .reset_n(reset_n), .DATA_IN(DATA_IN), .DATA_SYNC(DATA_SYNC),
        .ADC_OTR(ADC_OTR), .rx_i(rx_i), .rx_q(rx_q), .rx_valid(rx_valid),
        .DATA_OUT(DATA_OUT), .freq_out(freq_out), .preamp_enable(preamp_enable),
        .rx(rx), .tx(tx), .TX_I(TX_I), .TX_Q(TX_Q), .tx_valid(tx_valid),
        .cmd_error(cmd_error), .stage_debug(stage_debug)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          at;
        int          sel;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t        chkq[$];
    logic [31:0] txq[$];
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [31:0] get(input int sel);
        case (sel)
            S_FREQ:  return 32'(freq_out);
            S_PRE:   return 32'(preamp_enable);
            S_RX:    return 32'(rx);
            S_TX:    return 32'(tx);
            S_DOUT:  return 32'(DATA_OUT);
            S_TXI:   return 32'(TX_I);
            S_TXQ:   return 32'(TX_Q);
            S_TXV:   return 32'(tx_valid);
            S_ERR:   return 32'(cmd_error);
            default: return 32'(stage_debug);
        endcase
    endfunction

    // Expected value of one output, due at the next mid-cycle sample.
    task automatic exp_chk(input int sel, input logic [31:0] v, input string n);
        chk_t c;
        c.at = cyc; c.sel = sel; c.exp = v; c.name = n;
        chkq.push_back(c);
    endtask

    task automatic beat(input logic s, input logic [BW-1:0] d);
        DATA_SYNC = s;
        DATA_IN   = d;
        @(posedge clk_in);
        #1;
        DATA_SYNC = 1'b0;
    endtask

    always @(negedge clk_in) begin : monitor
        chk_t        c;
        logic [31:0] t;
        while (chkq.size() > 0 && chkq[0].at <= cyc) begin
            c = chkq.pop_front();
            compared++;
            if (c.at != cyc || get(c.sel) !== c.exp) begin
                mismatched++;
                $display("FAIL %s @cyc %0d: got %0h, want %0h", c.name, cyc, get(c.sel), c.exp);
            end
        end
        if (tx_valid === 1'b1) begin
            compared++;
            if (txq.size() == 0) begin
                mismatched++;
                $display("FAIL tx_strobe @cyc %0d: got unexpected tx_valid, want none", cyc);
            end else begin
                t = txq.pop_front();
                if ({TX_I, TX_Q} !== t) begin
                    mismatched++;
                    $display("FAIL tx_pair: got %0h, want %0h", {TX_I, TX_Q}, t);
                end
            end
        end
    end

    logic [27:0] pvec;
    logic [31:0] tvec;
    logic [63:0] rxexp;
    logic [15:0] evec;

    initial begin
        repeat (2) @(posedge clk_in);
        #1;
        reset_n = 1'b1;
        exp_chk(S_FREQ, 32'd620407, "rst_freq");
        exp_chk(S_PRE, 0, "rst_pre");
        exp_chk(S_RX, 1, "rst_rx");
        exp_chk(S_TX, 0, "rst_tx");
        exp_chk(S_DOUT, 0, "rst_dout");
        exp_chk(S_TXI, 0, "rst_txi");
        exp_chk(S_TXQ, 0, "rst_txq");
        exp_chk(S_TXV, 0, "rst_txv");
        exp_chk(S_ERR, 0, "rst_err");
        exp_chk(S_STAGE, 0, "rst_stage");

        // PARAMS: nothing commits before the last beat
        beat(1, 4'h1);
        exp_chk(S_STAGE, 1, "par_stage");
        pvec = 28'h83FFFFF;
        for (int k = 0; k < 7; k++) begin
            beat(0, pvec[27-4*k -: 4]);
            if (k < 6) begin
                exp_chk(S_FREQ, 32'd620407, "par_freq_hold");
                exp_chk(S_TX, 0, "par_tx_hold");
            end else begin
                exp_chk(S_FREQ, 32'h3FFFFF, "par_freq");
                exp_chk(S_TX, 1, "par_tx");
                exp_chk(S_RX, 0, "par_rx");
                exp_chk(S_PRE, 0, "par_pre");
                exp_chk(S_STAGE, 0, "par_idle");
            end
        end

        // PARAMS back to the default word, preamp on, receive mode
        beat(1, 4'h1);
        pvec = 28'h4097777;
        for (int k = 0; k < 7; k++) beat(0, pvec[27-4*k -: 4]);
        exp_chk(S_FREQ, 32'd620407, "par2_freq");
        exp_chk(S_PRE, 1, "par2_pre");
        exp_chk(S_RX, 1, "par2_rx");
        exp_chk(S_TX, 0, "par2_tx");

        // rx_new set, then abort a PARAMS with a STATUS command
        rx_valid = 1'b1;
        beat(0, 4'h0);
        rx_valid = 1'b0;
        beat(1, 4'h1);
        beat(0, 4'h8); beat(0, 4'h3); beat(0, 4'hF);
        beat(1, 4'h2);
        exp_chk(S_STAGE, 2, "abort_stage");
        exp_chk(S_FREQ, 32'd620407, "abort_freq");
        exp_chk(S_RX, 1, "abort_rx");
        beat(0, 4'h0);
        exp_chk(S_DOUT, 2, "abort_status");
        exp_chk(S_STAGE, 0, "status_idle");

        // sticky overrange
        ADC_OTR = 1'b1;
        beat(0, 4'h0);
        ADC_OTR = 1'b0;
        beat(1, 4'h2); beat(0, 4'h0);
        exp_chk(S_DOUT, 3, "otr_set");
        beat(1, 4'h2); beat(0, 4'h0);
        exp_chk(S_DOUT, 2, "otr_clr");

        // TX_IQ
        beat(1, 4'h3);
        tvec = 32'h80007FFF;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) txq.push_back({16'h7FFF, 16'h8000});
            beat(0, tvec[31-4*k -: 4]);
            if (k == 6) begin
                exp_chk(S_TXV, 0, "txiq_txv_early");
                exp_chk(S_TXQ, 0, "txiq_q_early");
            end
        end
        exp_chk(S_TXV, 1, "txiq_txv");
        exp_chk(S_TXI, 32'h7FFF, "txiq_i");
        exp_chk(S_TXQ, 32'h8000, "txiq_q");
        beat(0, 4'h0);
        exp_chk(S_TXV, 0, "txiq_txv_drop");

        // RX_IQ with inputs changed mid-transfer
        rx_i = {16'h7FFE, 16'hABCD};
        rx_q = {16'h8001, 16'h1234};
        rxexp = 64'h1234ABCD80017FFE;
        beat(1, 4'h4);
        exp_chk(S_STAGE, 4, "rxiq_stage");
        for (int k = 0; k < 16; k++) begin
            if (k == 1) begin
                rx_i = 32'hDEADBEEF;
                rx_q = 32'h55AA33CC;
            end
            beat(0, 4'h0);
            exp_chk(S_DOUT, 32'(rxexp[63-4*k -: 4]), "rxiq_beat");
        end
        exp_chk(S_STAGE, 0, "rxiq_idle");
        beat(1, 4'h2); beat(0, 4'h0);
        exp_chk(S_DOUT, 0, "rxnew_clr");

        // TEST loopback, then idle beat holds DATA_OUT
        beat(1, 4'hA);
        evec = 16'h5AC3;
        for (int k = 0; k < 4; k++) begin
            beat(0, evec[15-4*k -: 4]);
            exp_chk(S_DOUT, 32'(evec[15-4*k -: 4]), "test_loop");
        end
        exp_chk(S_STAGE, 0, "test_idle");
        beat(0, 4'h9);
        exp_chk(S_DOUT, 3, "idle_hold");

        // sync on the last PARAMS beat: no commit
        beat(1, 4'h1);
        pvec = 28'h83FFFFF;
        for (int k = 0; k < 6; k++) beat(0, pvec[27-4*k -: 4]);
        beat(1, 4'h2);
        exp_chk(S_FREQ, 32'd620407, "lastsync_freq");
        exp_chk(S_TX, 0, "lastsync_tx");
        exp_chk(S_STAGE, 2, "lastsync_stage");
        beat(0, 4'h0);
        exp_chk(S_DOUT, 0, "lastsync_status");

        // unknown opcode
        beat(1, 4'h7);
        exp_chk(S_ERR, 1, "err_pulse");
        exp_chk(S_STAGE, 0, "err_stage");
        exp_chk(S_FREQ, 32'd620407, "err_freq");
        exp_chk(S_PRE, 1, "err_pre");
        exp_chk(S_DOUT, 0, "err_dout");
        beat(0, 4'h0);
        exp_chk(S_ERR, 0, "err_drop");

        // reset during RX_IQ beat 5
        rx_i = {16'h7FFE, 16'hABCD};
        rx_q = {16'h8001, 16'h1234};
        beat(1, 4'h4);
        for (int k = 0; k < 4; k++) begin
            beat(0, 4'h0);
            if (k == 2) exp_chk(S_DOUT, 3, "pre_rst_dout");
        end
        reset_n = 1'b0;
        exp_chk(S_FREQ, 32'd620407, "arst_freq");
        exp_chk(S_PRE, 0, "arst_pre");
        exp_chk(S_RX, 1, "arst_rx");
        exp_chk(S_TX, 0, "arst_tx");
        exp_chk(S_DOUT, 0, "arst_dout");
        exp_chk(S_TXI, 0, "arst_txi");
        exp_chk(S_TXQ, 0, "arst_txq");
        exp_chk(S_STAGE, 0, "arst_stage");
        repeat (2) @(negedge clk_in);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_in);
        #1;

        compared++;
        if (chkq.size() != 0) begin
            mismatched++;
            $display("FAIL chk_drain: got %0d pending checks, want 0", chkq.size());
        end
        compared++;
        if (txq.size() != 0) begin
            mismatched++;
            $display("FAIL tx_drain: got %0d pending tx pairs, want 0", txq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish before 200000");
        $fatal(1);
    end

endmodule
